// File: rtl/alu_share_sched_if.sv
// Bundle of requester, ALU and response signals around the shared-ALU scheduler.
// master is the scheduler side; slave is the requester/ALU side.
interface alu_share_sched_if #(
    parameter int NUM_REQ    = 4,
    parameter int ACTION_LEN = 64,
    parameter int DATA_WIDTH = 48
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ACTION_LEN-1:0] req_action;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op1;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op2;
    logic [ACTION_LEN-1:0]         alu_action;
    logic                          alu_action_valid;
    logic [DATA_WIDTH-1:0]         alu_op1;
    logic [DATA_WIDTH-1:0]         alu_op2;
    logic [DATA_WIDTH-1:0]         alu_result;
    logic                          alu_result_valid;
    logic [NUM_REQ-1:0]            resp_valid;
    logic [DATA_WIDTH-1:0]         resp_data;
    logic                          resp_err;
    logic                          err_spurious;

    modport master (
        input  req_valid, req_action, req_op1, req_op2,
        input  alu_result, alu_result_valid,
        output req_ready,
        output alu_action, alu_action_valid, alu_op1, alu_op2,
        output resp_valid, resp_data, resp_err, err_spurious
    );

    modport slave (
        output req_valid, req_action, req_op1, req_op2,
        output alu_result, alu_result_valid,
        input  req_ready,
        input  alu_action, alu_action_valid, alu_op1, alu_op2,
        input  resp_valid, resp_data, resp_err, err_spurious
    );
endinterface

// File: rtl/alu_share_sched.sv
// Round-robin scheduler sharing one single-issue ALU among NUM_REQ requesters.
// One op in flight: grant, issue, wait for result or timeout, respond one-hot.
module alu_share_sched #(
    parameter int NUM_REQ    = 4,
    parameter int ACTION_LEN = 64,
    parameter int DATA_WIDTH = 48,
    parameter int TIMEOUT    = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sched_en,
    alu_share_sched_if.master bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [PTR_W-1:0]      r_ptr;
    logic [PTR_W-1:0]      r_grant;
    logic [PTR_W-1:0]      w_gidx;
    logic [PTR_W-1:0]      w_ptr_nxt;
    logic                  w_found;
    logic                  w_take;
    logic                  w_tmo;
    logic [7:0]            r_timer;
    logic [NUM_REQ-1:0]    w_ready;
    logic [ACTION_LEN-1:0] r_alu_action;
    logic                  r_alu_valid;
    logic [DATA_WIDTH-1:0] r_alu_op1;
    logic [DATA_WIDTH-1:0] r_alu_op2;
    logic [NUM_REQ-1:0]    r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_data;
    logic                  r_resp_err;
    logic                  r_spur;

    function automatic logic [NUM_REQ-1:0] f_onehot(input logic [PTR_W-1:0] i);
        logic [NUM_REQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // First valid requester scanning from r_ptr with wrap at NUM_REQ-1
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_gidx  = '0;
        idx     = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_found && bus.req_valid[idx]) begin
                w_found = 1'b1;
                w_gidx  = PTR_W'(idx);
            end
        end
    end

    assign w_take = rst_n && sched_en && (r_state == S_IDLE) && w_found;
    assign w_tmo  = (r_timer == 8'(TIMEOUT - 1));
    assign w_ptr_nxt = (r_grant == PTR_W'(NUM_REQ - 1)) ?
                       '0 : r_grant + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_take) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (bus.alu_result_valid || w_tmo) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = '0;
        if (w_take) w_ready = f_onehot(w_gidx);
    end

    assign bus.req_ready = w_ready;

    // Grant capture and ALU drive; alu_* hold the last issued op
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_grant      <= '0;
            r_alu_action <= '0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_alu_valid  <= 1'b0;
        end else begin
            r_alu_valid <= w_take;
            if (w_take) begin
                r_grant      <= w_gidx;
                r_alu_action <= bus.req_action[int'(w_gidx)*ACTION_LEN +: ACTION_LEN];
                r_alu_op1    <= bus.req_op1[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
                r_alu_op2    <= bus.req_op2[int'(w_gidx)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer      <= '0;
            r_ptr        <= '0;
            r_resp_valid <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= '0;
            r_resp_err   <= 1'b0;
            if (r_state == S_ISSUE) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT) begin
                if (bus.alu_result_valid) begin
                    r_resp_valid <= f_onehot(r_grant);
                    r_resp_data  <= bus.alu_result;
                    r_ptr        <= w_ptr_nxt;
                end else if (w_tmo) begin
                    r_resp_valid <= f_onehot(r_grant);
                    r_resp_data  <= '0;
                    r_resp_err   <= 1'b1;
                    r_ptr        <= w_ptr_nxt;
                end else begin
                    r_timer <= r_timer + 8'd1;
                end
            end
        end
    end

    // A result outside WAIT is dropped and latched as an error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_spur <= 1'b0;
        else if (bus.alu_result_valid && (r_state != S_WAIT)) r_spur <= 1'b1;
    end

    assign bus.alu_action       = r_alu_action;
    assign bus.alu_action_valid = r_alu_valid;
    assign bus.alu_op1          = r_alu_op1;
    assign bus.alu_op2          = r_alu_op2;
    assign bus.resp_valid       = r_resp_valid;
    assign bus.resp_data        = r_resp_data;
    assign bus.resp_err         = r_resp_err;
    assign bus.err_spurious     = r_spur;
endmodule

// File: tb/tb_alu_share_sched.sv
// Directed bench for alu_share_sched with a 2-cycle adder ALU model.
// Inputs change and outputs are sampled on the falling edge.
module tb_alu_share_sched;
    localparam int NR = 4;
    localparam int AL = 64;
    localparam int DW = 48;

    logic clk;
    logic rst_n;
    logic sched_en;
    logic alu_on;
    logic spur;
    logic          s1, s2;
    logic [DW-1:0] d1, d2;
    int n_cmp;
    int n_bad;

    alu_share_sched_if #(.NUM_REQ(NR), .ACTION_LEN(AL), .DATA_WIDTH(DW)) bus ();

    alu_share_sched #(
        .NUM_REQ(NR), .ACTION_LEN(AL), .DATA_WIDTH(DW), .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .sched_en(sched_en),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU: result valid two cycles after the issue cycle
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0; s2 <= 1'b0; d1 <= '0; d2 <= '0;
        end else begin
            s1 <= alu_on && bus.alu_action_valid;
            d1 <= bus.alu_op1 + bus.alu_op2;
            s2 <= s1;
            d2 <= d1;
        end
    end

    assign bus.alu_result_valid = s2 | spur;
    assign bus.alu_result       = d2;

    task automatic set_req(input int i, input logic [AL-1:0] act,
                           input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_action[i*AL +: AL] = act;
        bus.req_op1[i*DW +: DW]    = a;
        bus.req_op2[i*DW +: DW]    = b;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = '0; bus.req_action = '0;
        bus.req_op1 = '0; bus.req_op2 = '0;
        sched_en = 1'b1; alu_on = 1'b1; spur = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0 || bus.alu_action_valid !== 1'b0 ||
            bus.resp_valid !== 4'b0 || bus.resp_err !== 1'b0 ||
            bus.err_spurious !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl rdy=%b av=%b rv=%b re=%b es=%b want all 0",
                     bus.req_ready, bus.alu_action_valid, bus.resp_valid,
                     bus.resp_err, bus.err_spurious);
        end
        n_cmp++;
        if (bus.alu_action !== 64'd0 || bus.alu_op1 !== 48'd0 ||
            bus.resp_data !== 48'd0) begin
            n_bad++;
            $display("FAIL reset_data act=%h op1=%h rd=%h want 0",
                     bus.alu_action, bus.alu_op1, bus.resp_data);
        end
    endtask

    task automatic test_single_op();
        logic [AL-1:0] act;
        act = 64'd1 << 21;
        @(negedge clk);
        set_req(0, act, 48'd10, 48'd3);
        bus.req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL single_ready got=%b want=0001", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        n_cmp++;
        if (bus.alu_action_valid !== 1'b1 || bus.alu_op1 !== 48'd10 ||
            bus.alu_op2 !== 48'd3 || bus.alu_action !== act) begin
            n_bad++;
            $display("FAIL single_issue av=%b op1=%0d op2=%0d act=%h want 1/10/3/%h",
                     bus.alu_action_valid, bus.alu_op1, bus.alu_op2, bus.alu_action, act);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.alu_action_valid !== 1'b0 || bus.alu_op1 !== 48'd10) begin
            n_bad++;
            $display("FAIL single_hold av=%b op1=%0d want 0/10",
                     bus.alu_action_valid, bus.alu_op1);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.resp_valid !== 4'b0) begin
            n_bad++;
            $display("FAIL single_early got=%b want=0000", bus.resp_valid);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.resp_valid !== 4'b0001 || bus.resp_data !== 48'd13 ||
            bus.resp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL single_resp rv=%b rd=%0d re=%b want 0001/13/0",
                     bus.resp_valid, bus.resp_data, bus.resp_err);
        end
        @(negedge clk);
        n_cmp++;
        if (bus.resp_valid !== 4'b0 || bus.resp_data !== 48'd13) begin
            n_bad++;
            $display("FAIL single_after rv=%b rd=%0d want 0000/13",
                     bus.resp_valid, bus.resp_data);
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] exp_rdy;
        logic [NR-1:0] exp_rv;
        logic [DW-1:0] exp_d;
        int g;
        apply_reset();
        for (int i = 0; i < NR; i++)
            set_req(i, AL'(i + 1), DW'(100 * (i + 1)), DW'(i + 7));
        bus.req_valid = 4'b1111;
        #1;
        for (int c = 0; c <= 16; c++) begin
            if (c > 0) begin
                @(negedge clk);
                #1;
            end
            exp_rdy = '0;
            if (c % 4 == 0) exp_rdy = 4'b0001 << ((c / 4) % 4);
            n_cmp++;
            if (bus.req_ready !== exp_rdy) begin
                n_bad++;
                $display("FAIL rr_ready c=%0d got=%b want=%b", c, bus.req_ready, exp_rdy);
            end
            if (c >= 4 && c % 4 == 0) begin
                g = (c / 4) - 1;
                exp_rv = 4'b0001 << g;
                exp_d  = DW'(100 * (g + 1) + g + 7);
                n_cmp++;
                if (bus.resp_valid !== exp_rv || bus.resp_data !== exp_d) begin
                    n_bad++;
                    $display("FAIL rr_resp c=%0d rv=%b rd=%0d want %b/%0d",
                             c, bus.resp_valid, bus.resp_data, exp_rv, exp_d);
                end
            end
        end
        bus.req_valid = '0;
    endtask

    task automatic test_timeout();
        apply_reset();
        alu_on = 1'b0;
        set_req(2, 64'hA5, 48'd5, 48'd6);
        bus.req_valid = 4'b0100;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0100) begin
            n_bad++;
            $display("FAIL tmo_ready got=%b want=0100", bus.req_ready);
        end
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (i == 1) bus.req_valid = '0;
            n_cmp++;
            if (bus.resp_valid !== 4'b0) begin
                n_bad++;
                $display("FAIL tmo_early i=%0d got=%b want=0000", i, bus.resp_valid);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (bus.resp_valid !== 4'b0100 || bus.resp_err !== 1'b1 ||
            bus.resp_data !== 48'd0) begin
            n_bad++;
            $display("FAIL tmo_resp rv=%b re=%b rd=%0d want 0100/1/0",
                     bus.resp_valid, bus.resp_err, bus.resp_data);
        end
        alu_on = 1'b1;
        set_req(1, 64'h3, 48'd40, 48'd2);
        bus.req_valid = 4'b0010;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL tmo_next_ready got=%b want=0010", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.resp_valid !== 4'b0010 || bus.resp_err !== 1'b0 ||
            bus.resp_data !== 48'd42) begin
            n_bad++;
            $display("FAIL tmo_next_resp rv=%b re=%b rd=%0d want 0010/0/42",
                     bus.resp_valid, bus.resp_err, bus.resp_data);
        end
    endtask

    task automatic test_spurious();
        apply_reset();
        @(negedge clk);
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        n_cmp++;
        if (bus.err_spurious !== 1'b1 || bus.resp_valid !== 4'b0) begin
            n_bad++;
            $display("FAIL spur_set es=%b rv=%b want 1/0000",
                     bus.err_spurious, bus.resp_valid);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.err_spurious !== 1'b1 || bus.resp_valid !== 4'b0) begin
            n_bad++;
            $display("FAIL spur_sticky es=%b rv=%b want 1/0000",
                     bus.err_spurious, bus.resp_valid);
        end
    endtask

    task automatic test_sched_en();
        apply_reset();
        set_req(0, 64'h7, 48'd20, 48'd5);
        set_req(1, 64'h8, 48'd30, 48'd1);
        bus.req_valid = 4'b0001;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL en_ready got=%b want=0001", bus.req_ready);
        end
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                sched_en = 1'b0;
                bus.req_valid = 4'b0010;
            end
            #1;
            n_cmp++;
            if (bus.req_ready !== 4'b0) begin
                n_bad++;
                $display("FAIL en_block i=%0d got=%b want=0000", i, bus.req_ready);
            end
            if (i == 4) begin
                n_cmp++;
                if (bus.resp_valid !== 4'b0001 || bus.resp_data !== 48'd25) begin
                    n_bad++;
                    $display("FAIL en_resp rv=%b rd=%0d want 0001/25",
                             bus.resp_valid, bus.resp_data);
                end
            end
        end
        sched_en = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL en_resume got=%b want=0010", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        alu_on = 1'b0;
        set_req(1, 64'h55, 48'd9, 48'd9);
        bus.req_valid = 4'b0010;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0010) begin
            n_bad++;
            $display("FAIL rstop_ready got=%b want=0010", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        bus.req_valid = 4'b1111;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0 || bus.alu_action !== 64'd0 ||
            bus.alu_op1 !== 48'd0 || bus.resp_valid !== 4'b0) begin
            n_bad++;
            $display("FAIL rstop_clear rdy=%b act=%h op1=%0d rv=%b want 0",
                     bus.req_ready, bus.alu_action, bus.alu_op1, bus.resp_valid);
        end
        alu_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (bus.req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL rstop_first got=%b want=0001", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = '0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        sched_en = 1'b0;
        alu_on = 1'b1;
        spur = 1'b0;
        bus.req_valid = '0;
        bus.req_action = '0;
        bus.req_op1 = '0;
        bus.req_op2 = '0;
        test_reset();
        test_single_op();
        test_round_robin();
        test_timeout();
        test_spurious();
        test_sched_en();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
